// File: rtl/acc5_if.sv
// ---------------------------------------------------------------------------
// acc5_if -- signal bundle between the acc5_seq accumulator controller and
// its surroundings (operand source, 5-bit ripple-carry adder, result sink).
//
// Groups:
//   operand stream : in_valid, in_ready, in_data[4:0], in_sub, in_last
//   adder drive    : add_a[4:0], add_b[4:0], add_ci
//   adder return   : sum_s[4:0], sum_co
//   result stream  : out_valid, out_ready, out_sum[4:0], out_events[3:0]
//
// Modports:
//   master : the accumulator controller (drives in_ready, adder operands and
//            the result stream).
//   slave  : the environment (operand source, adder, result consumer).
// ---------------------------------------------------------------------------
interface acc5_if;
    // operand stream
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic       in_sub;
    logic       in_last;

    // adder operands and result
    logic [4:0] add_a;
    logic [4:0] add_b;
    logic       add_ci;
    logic [4:0] sum_s;
    logic       sum_co;

    // result stream
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sum;
    logic [3:0] out_events;

    modport master (
        input  in_valid, in_data, in_sub, in_last,
        output in_ready,
        output add_a, add_b, add_ci,
        input  sum_s, sum_co,
        output out_valid, out_sum, out_events,
        input  out_ready
    );

    modport slave (
        output in_valid, in_data, in_sub, in_last,
        input  in_ready,
        input  add_a, add_b, add_ci,
        output sum_s, sum_co,
        input  out_valid, out_sum, out_events,
        output out_ready
    );
endinterface

// File: rtl/acc5_seq.sv
// ---------------------------------------------------------------------------
// acc5_seq -- sequential accumulator controller around a 5-bit ripple-carry
// adder.
//
// Operand beats arrive on the input stream; each accepted beat is added to
// (or subtracted from) a running 5-bit accumulator using the external adder.
// Carry-outs on adds and borrows on subtracts are counted (saturating at 15).
// When the last beat of a packet is accepted, the packet total and event
// count are offered on the result stream until the consumer takes them.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous, active-low reset (priority over everything)
//   clr       : synchronous abort back to IDLE (priority over all but reset)
//   bus       : acc5_if.master -- operand stream, adder drive/return,
//               result stream
//   dbg_state : current FSM state (0 IDLE, 1 ACCUM, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and its payload steady until that edge;
// ready may change freely and never depends combinationally on valid.
// ---------------------------------------------------------------------------
module acc5_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    acc5_if.master       bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] acc;
    logic [3:0] evt;

    logic       accept;
    logic       beat_event;
    logic [3:0] evt_next;

    // Adder drive: subtraction is acc + ~data + 1 (two's complement).
    assign bus.add_a  = acc;
    assign bus.add_b  = bus.in_sub ? ~bus.in_data : bus.in_data;
    assign bus.add_ci = bus.in_sub;

    // Ready only while collecting beats; DONE blocks new input until the
    // result has been handed off.
    assign bus.in_ready = (state != DONE);
    assign accept       = bus.in_valid & bus.in_ready;

    // An add that carries out, or a subtract that does not (a borrow).
    assign beat_event = bus.in_sub ^ bus.sum_co;

    // Saturating increment: the counter sticks at 15 instead of wrapping.
    assign evt_next = (evt == 4'hF) ? evt : evt + {3'b000, beat_event};

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            acc            <= '0;
            evt            <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_sum    <= '0;
            bus.out_events <= '0;
        end else if (clr) begin
            // Abort: any beat presented this cycle is dropped. The result
            // registers keep their old values but are no longer valid.
            state         <= IDLE;
            acc           <= '0;
            evt           <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= bus.sum_s;
                        evt <= evt_next;
                        if (bus.in_last) begin
                            // Result is captured from the adder directly so
                            // it includes the final beat.
                            state          <= DONE;
                            bus.out_sum    <= bus.sum_s;
                            bus.out_events <= evt_next;
                            bus.out_valid  <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end

                DONE: begin
                    // out_sum/out_events stay frozen until the consumer
                    // takes them; the next packet starts from zero.
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        acc           <= '0;
                        evt           <= '0;
                        bus.out_valid <= 1'b0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    acc           <= '0;
                    evt           <= '0;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
